// File: rtl/pcs_pkg.sv
// Shared PCS receive-path definitions: block-lock FSM states and 64b/66b sync-header helpers.
package pcs_pkg;

  typedef enum logic [2:0] {
    LOCK_INIT,
    TEST,
    LOCKED,
    SLIP,
    SLIP_WAIT
  } lock_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // A sync header is legal only when its two bits differ (01 data, 10 control).
  function automatic logic is_valid_sh(input logic [1:0] hdr);
    return hdr[1] ^ hdr[0];
  endfunction

endpackage

// File: rtl/rx_block_lock_fsm.sv
// 64b/66b block-lock controller: hunts for sync-header alignment with gearbox bitslips,
// declares lock after a clean window and drops it when a window sees too many bad headers.
module rx_block_lock_fsm #(
  parameter int HDR_WIDTH      = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [HDR_WIDTH-1:0] i_rx_hdr,
  input  logic                 i_rx_hdr_valid,
  output logic                 o_bitslip,
  output logic                 o_block_lock,
  output logic [CNT_WIDTH-1:0] o_slip_count
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);

  pcs_pkg::lock_state_t state_q, state_d;

  logic [SH_W-1:0]      sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]     sh_invalid_cnt_q, sh_invalid_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 bitslip_q, bitslip_d;
  logic                 block_lock_q, block_lock_d;
  logic [CNT_WIDTH-1:0] slip_count_q, slip_count_d;

  logic                 hdr_ok;
  logic                 hdr_bad;
  logic [SH_W-1:0]      sh_cnt_inc;
  logic [INV_W-1:0]     sh_invalid_inc;
  logic                 win_done;
  logic                 inv_limit;
  logic                 slip_req;

  assign hdr_ok         = pcs_pkg::is_valid_sh(i_rx_hdr[1:0]);
  assign hdr_bad        = ~hdr_ok;
  assign sh_cnt_inc     = sh_cnt_q + SH_W'(1);
  assign sh_invalid_inc = sh_invalid_cnt_q + INV_W'(hdr_bad);
  assign win_done       = (sh_cnt_inc == SH_LAST);
  assign inv_limit      = (sh_invalid_inc == INV_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= pcs_pkg::LOCK_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      pcs_pkg::LOCK_INIT: state_d = pcs_pkg::TEST;
      pcs_pkg::TEST: begin
        if (i_rx_hdr_valid) begin
          if (hdr_bad) begin
            state_d = pcs_pkg::SLIP;
          end else if (win_done) begin
            state_d = pcs_pkg::LOCKED;
          end
        end
      end
      // The invalid limit is checked first so it wins when it coincides with window end.
      pcs_pkg::LOCKED: begin
        if (i_rx_hdr_valid && inv_limit) begin
          state_d = pcs_pkg::SLIP;
        end
      end
      pcs_pkg::SLIP: state_d = pcs_pkg::SLIP_WAIT;
      pcs_pkg::SLIP_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = pcs_pkg::TEST;
        end
      end
      default: state_d = pcs_pkg::LOCK_INIT;
    endcase
  end

  // The slip pulse is registered on the transition into SLIP, so it appears the cycle after the trigger.
  assign slip_req = (state_d == pcs_pkg::SLIP);

  always_comb begin
    sh_cnt_d         = sh_cnt_q;
    sh_invalid_cnt_d = sh_invalid_cnt_q;
    wait_cnt_d       = wait_cnt_q;
    block_lock_d     = block_lock_q;
    bitslip_d        = slip_req;
    slip_count_d     = slip_count_q;
    if (slip_req && !(&slip_count_q)) begin
      slip_count_d = slip_count_q + CNT_WIDTH'(1);
    end
    case (state_q)
      pcs_pkg::LOCK_INIT: begin
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
        block_lock_d     = 1'b0;
      end
      pcs_pkg::TEST: begin
        block_lock_d = 1'b0;
        if (i_rx_hdr_valid && hdr_ok) begin
          if (win_done) begin
            block_lock_d     = 1'b1;
            sh_cnt_d         = '0;
            sh_invalid_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_inc;
          end
        end
      end
      pcs_pkg::LOCKED: begin
        if (i_rx_hdr_valid) begin
          if (inv_limit) begin
            block_lock_d = 1'b0;
          end else if (win_done) begin
            sh_cnt_d         = '0;
            sh_invalid_cnt_d = '0;
          end else begin
            sh_cnt_d         = sh_cnt_inc;
            sh_invalid_cnt_d = sh_invalid_inc;
          end
        end
      end
      pcs_pkg::SLIP: begin
        block_lock_d = 1'b0;
        wait_cnt_d   = WAIT_LOAD;
      end
      pcs_pkg::SLIP_WAIT: begin
        if (wait_cnt_q == '0) begin
          sh_cnt_d         = '0;
          sh_invalid_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      default: begin
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
        block_lock_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sh_cnt_q         <= '0;
      sh_invalid_cnt_q <= '0;
      wait_cnt_q       <= '0;
      bitslip_q        <= 1'b0;
      block_lock_q     <= 1'b0;
      slip_count_q     <= '0;
    end else begin
      sh_cnt_q         <= sh_cnt_d;
      sh_invalid_cnt_q <= sh_invalid_cnt_d;
      wait_cnt_q       <= wait_cnt_d;
      bitslip_q        <= bitslip_d;
      block_lock_q     <= block_lock_d;
      slip_count_q     <= slip_count_d;
    end
  end

  assign o_bitslip    = bitslip_q;
  assign o_block_lock = block_lock_q;
  assign o_slip_count = slip_count_q;

endmodule

// File: tb/tb_rx_block_lock_fsm.sv
// Scoreboard bench for rx_block_lock_fsm: directed header streams queue expected lock/slip events,
// a negedge monitor pops and compares them; a second narrow-counter instance checks slip saturation.
module tb_rx_block_lock_fsm;

  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_SLIP = 4;
  localparam int SLIP_PERIOD = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rx_hdr;
  logic        rx_hdr_valid;
  logic        bitslip;
  logic        block_lock;
  logic [15:0] slip_count;
  logic [1:0]  hdr4;
  logic        valid4;
  logic        bitslip4;
  logic        lock4;
  logic [3:0]  slip_count4;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  typedef enum int {EV_LOCK_UP, EV_LOCK_DN, EV_SLIP} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [15:0] cnt;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_block_lock_fsm dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_rx_hdr       (rx_hdr),
    .i_rx_hdr_valid (rx_hdr_valid),
    .o_bitslip      (bitslip),
    .o_block_lock   (block_lock),
    .o_slip_count   (slip_count)
  );

  rx_block_lock_fsm #(.CNT_WIDTH(4)) dut4 (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_rx_hdr       (hdr4),
    .i_rx_hdr_valid (valid4),
    .o_bitslip      (bitslip4),
    .o_block_lock   (lock4),
    .o_slip_count   (slip_count4)
  );

  function automatic void push(input ev_kind_t k, input int c, input logic [15:0] n);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = n;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic check_event(input ev_kind_t k);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required no event", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == EV_SLIP && e.cnt !== slip_count)) begin
        n_fail++;
        $display("FAIL event_compare: got %s cycle %0d count %0d, required %s cycle %0d count %0d",
                 k.name(), cyc, slip_count, e.kind.name(), e.cyc, e.cnt);
      end else begin
        $display("event %s at cycle %0d count %0d ok", k.name(), cyc, slip_count);
      end
    end
  endtask

  // Monitor: a change on o_block_lock or a high o_bitslip is a DUT transaction.
  initial begin
    logic lock_prev;
    lock_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (block_lock !== lock_prev) check_event(block_lock ? EV_LOCK_UP : EV_LOCK_DN);
      if (bitslip === 1'b1) check_event(EV_SLIP);
      lock_prev = block_lock;
    end
  end

  // One header beat: valid for one cycle, then an idle cycle carrying an illegal header.
  task automatic beat(input logic [1:0] h, input int mask, input logic [15:0] cnt);
    @(negedge clk);
    rx_hdr       = h;
    rx_hdr_valid = 1'b1;
    if ((mask & M_UP) != 0)   push(EV_LOCK_UP, cyc + 1, cnt);
    if ((mask & M_DN) != 0)   push(EV_LOCK_DN, cyc + 1, cnt);
    if ((mask & M_SLIP) != 0) push(EV_SLIP, cyc + 1, cnt);
    @(negedge clk);
    rx_hdr       = 2'b11;
    rx_hdr_valid = 1'b0;
  endtask

  // 16 beats of 2'b11 that must all fall inside the post-slip blanking interval.
  task automatic ignore16();
    for (int i = 0; i < 16; i++) beat(2'b11, 0, 16'd0);
  endtask

  task automatic acquire();
    for (int i = 0; i < 64; i++) beat(2'b01, (i == 63) ? M_UP : 0, 16'd0);
  endtask

  initial begin
    int s0;
    int k;
    bit exp_slip;
    rst_n        = 1'b0;
    rx_hdr       = 2'b00;
    rx_hdr_valid = 1'b0;
    hdr4         = 2'b00;
    valid4       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_bitslip", 32'(bitslip), 32'd0);
    chk("reset_lock", 32'(block_lock), 32'd0);
    chk("reset_slip_count", 32'(slip_count), 32'd0);
    chk("reset_slip_count4", 32'(slip_count4), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Acquire lock from clean headers
    acquire();
    chk("s1_lock", 32'(block_lock), 32'd1);
    chk("s1_slip_count", 32'(slip_count), 32'd0);

    // Locked: 15 invalid in one window holds lock, then 16 in the next window drops it
    for (int i = 0; i < 64; i++) beat(((i % 4) == 1 && i < 60) ? 2'b00 : 2'b01, 0, 16'd0);
    chk("s3_lock_hold", 32'(block_lock), 32'd1);
    for (int i = 0; i < 32; i++)
      beat(((i % 2) == 1) ? 2'b00 : 2'b10, (i == 31) ? (M_DN | M_SLIP) : 0, 16'd1);
    ignore16();

    // Unlocked: invalid header after 10 good ones slips, then full re-acquire
    for (int i = 0; i < 10; i++) beat(2'b10, 0, 16'd0);
    beat(2'b11, M_SLIP, 16'd2);
    ignore16();
    acquire();

    // Locked: 16th invalid header coincides with the 64th header of the window
    for (int i = 0; i < 64; i++)
      beat((i < 48) ? 2'b01 : 2'b00, (i == 63) ? (M_DN | M_SLIP) : 0, 16'd3);
    ignore16();
    chk("s4_lock", 32'(block_lock), 32'd0);

    // Asynchronous reset during the bitslip cycle
    @(negedge clk);
    rx_hdr       = 2'b11;
    rx_hdr_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_hdr_valid = 1'b0;
    chk("s6_bitslip_before_rst", 32'(bitslip), 32'd1);
    chk("s6_count_before_rst", 32'(slip_count), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("s6_bitslip_async_clear", 32'(bitslip), 32'd0);
    chk("s6_count_async_clear", 32'(slip_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    acquire();

    // Asynchronous reset while locked
    @(posedge clk);
    #2;
    push(EV_LOCK_DN, cyc, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("s6_lock_async_clear", 32'(block_lock), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous illegal headers on the 4-bit-counter instance: periodic slips, saturating count
    @(negedge clk);
    hdr4   = 2'b11;
    valid4 = 1'b1;
    s0     = cyc + 1;
    repeat (16 * SLIP_PERIOD + 3) begin
      @(negedge clk);
      k        = (cyc - s0) / SLIP_PERIOD;
      exp_slip = ((cyc - s0) % SLIP_PERIOD) == 0;
      if (exp_slip) begin
        chk($sformatf("s5_slip%0d_pulse", k), 32'(bitslip4), 32'd1);
        chk($sformatf("s5_slip%0d_count", k), 32'(slip_count4), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
      end else if (bitslip4 !== 1'b0) begin
        n_vec++;
        n_fail++;
        $display("FAIL s5_spacing: got bitslip %0b at cycle %0d, required 0", bitslip4, cyc);
      end
    end
    valid4 = 1'b0;

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
